// File: rtl/srt_div_pkg.sv
// Shared types for the SRT divider request front-end.
// Holds the FSM encoding, default widths and the request/response layouts.
package srt_div_pkg;

  localparam int SRT_WID  = 8;
  localparam int SRT_TAGW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } srt_state_e;

  // Default-width layouts; the front-end re-declares the same field order
  // with its own WID/TAGW so non-default builds stay consistent.
  typedef struct packed {
    logic [SRT_TAGW-1:0] tag;
    logic                sign;
    logic [SRT_WID-1:0]  divisor;
    logic [SRT_WID-1:0]  dividend;
  } srt_req_t;

  typedef struct packed {
    logic [SRT_TAGW-1:0] tag;
    logic                err;
    logic [SRT_WID-1:0]  remainder;
    logic [SRT_WID-1:0]  quotient;
  } srt_resp_t;

endpackage

// File: rtl/srt_div_frontend_fifo.sv
// srt_req_fifo: small synchronous FIFO for divide requests.
// Push and pop in the same cycle keep the count unchanged, including when full.
module srt_req_fifo #(
  parameter int W     = 21,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO may still push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next-state for storage, pointers (natural wrap) and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/srt_div_frontend.sv
// srt_div_frontend: queues tagged divide requests, issues them one at a time
// to the SRT radix-4 core with a one-cycle start pulse, and holds the result
// as a registered response under valid/ready backpressure.
// Optional macro SRT_DIV_TIMEOUT_EN: bounds WAIT to TIMEOUT cycles and then
// answers with an error response.
module srt_div_frontend
  import srt_div_pkg::*;
#(
  parameter int WID     = SRT_WID,
  parameter int DEPTH   = 4,
  parameter int TAGW    = SRT_TAGW,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [WID-1:0]  req_dividend,
  input  logic [WID-1:0]  req_divisor,
  input  logic            req_sign,
  input  logic [TAGW-1:0] req_tag,
  output logic            div_valid,
  output logic [WID-1:0]  div_dividend,
  output logic [WID-1:0]  div_divisor,
  output logic            div_sign,
  input  logic            div_ready,
  input  logic            div_error,
  input  logic [WID-1:0]  div_quotient,
  input  logic [WID-1:0]  div_remainder,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [WID-1:0]  resp_quotient,
  output logic [WID-1:0]  resp_remainder,
  output logic            resp_err,
  output logic [TAGW-1:0] resp_tag
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_cfg_err
    $error("srt_div_frontend: DEPTH must be a power of two >= 2, TIMEOUT >= 1");
  end

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic            sign;
    logic [WID-1:0]  divisor;
    logic [WID-1:0]  dividend;
  } req_t;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic            err;
    logic [WID-1:0]  remainder;
    logic [WID-1:0]  quotient;
  } resp_t;

  srt_state_e  state_q, state_d;
  req_t        issue_q, issue_d;
  resp_t       resp_q, resp_d;
  req_t        fifo_in, fifo_head;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [AW:0] fifo_count;
  logic        timeout_hit;

  assign req_ready = (fifo_count < (AW+1)'(DEPTH));
  assign fifo_push = req_valid & ~fifo_full;
  assign fifo_in   = '{tag: req_tag, sign: req_sign,
                       divisor: req_divisor, dividend: req_dividend};

  srt_req_fifo #(
    .W     ($bits(req_t)),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (fifo_in),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef SRT_DIV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  // The count would reach TIMEOUT at the end of this cycle: give up now.
  assign timeout_hit = (state_q == ST_WAIT) && (wait_cnt_q == CW'(TIMEOUT - 1));

  // Count WAIT cycles; restart on every issue.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ST_ISSUE)     wait_cnt_d = '0;
    else if (state_q == ST_WAIT) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Single-divide-in-flight sequencer. Operands are latched when leaving
  // IDLE so they are already stable during the ISSUE start pulse; the FIFO
  // head is popped in ISSUE. Error beats a simultaneous ready, and a real
  // result beats a timeout landing in the same cycle.
  always_comb begin
    state_d  = state_q;
    issue_d  = issue_q;
    resp_d   = resp_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          issue_d = fifo_head;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        fifo_pop = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (div_error) begin
          resp_d  = '{tag: issue_q.tag, err: 1'b1, remainder: '0, quotient: '0};
          state_d = ST_RESP;
        end else if (div_ready) begin
          resp_d  = '{tag: issue_q.tag, err: 1'b0,
                      remainder: div_remainder, quotient: div_quotient};
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          resp_d  = '{tag: issue_q.tag, err: 1'b1, remainder: '0, quotient: '0};
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, issue and response registers; reset drops any in-flight divide.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      issue_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      resp_q  <= resp_d;
    end
  end

  assign div_valid      = (state_q == ST_ISSUE);
  assign div_dividend   = issue_q.dividend;
  assign div_divisor    = issue_q.divisor;
  assign div_sign       = issue_q.sign;

  assign resp_valid     = (state_q == ST_RESP);
  assign resp_quotient  = resp_q.quotient;
  assign resp_remainder = resp_q.remainder;
  assign resp_err       = resp_q.err;
  assign resp_tag       = resp_q.tag;

endmodule

// File: doc/srt_div_frontend.md
Name: srt_div_frontend

Overview:
- Request front-end placed directly upstream of the SRT radix-4 divider core.
- Accepts tagged divide requests through a valid/ready handshake and buffers them in a small FIFO.
- Issues requests to the divider one at a time, using a single-cycle start pulse.
- Captures the divider's one-cycle result/error pulse and holds it as a registered response with valid/ready backpressure.

Parameters:
- WID, 8, operand/result width; must match the divider's WID.
- DEPTH, 4, request FIFO entries; power of two, ≥2.
- TAGW, 4, request tag width.
- TIMEOUT, 64, maximum WAIT cycles before forced error; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept (count < DEPTH)
- req_dividend  in  WID  dividend
- req_divisor  in  WID  divisor
- req_sign  in  1  1 = signed two's-complement divide
- req_tag  in  TAGW  opaque ID, returned with the response
- div_valid  out  1  start pulse to divider
- div_dividend  out  WID  operand to divider
- div_divisor  out  WID  operand to divider
- div_sign  out  1  sign mode to divider
- div_ready  in  1  divider result pulse; quotient/remainder valid this cycle only
- div_error  in  1  divider divide-by-zero pulse
- div_quotient  in  WID  divider quotient
- div_remainder  in  WID  divider remainder
- resp_valid  out  1  response held
- resp_ready  in  1  consumer accepts
- resp_quotient  out  WID  quotient
- resp_remainder  out  WID  remainder
- resp_err  out  1  divide-by-zero (or timeout)
- resp_tag  out  TAGW  tag of the originating request

Behaviour:
- Reset values: all outputs 0. FIFO empty, state IDLE. Because the FIFO is empty, req_ready=1 in the first cycle after reset.
- FIFO:
  - Push when req_valid & req_ready.
  - Pop on the ISSUE cycle.
  - Push and pop in the same cycle leave count unchanged; this is legal when full.
  - Read/write pointers are log2(DEPTH) bits and wrap naturally.
  - Count is log2(DEPTH)+1 bits.
- FSM, one divide in flight:
  - IDLE: if the FIFO is non-empty, go to ISSUE.
  - ISSUE (exactly 1 cycle):
    - div_valid=1.
    - div_dividend/div_divisor/div_sign/tag come from the FIFO head, registered into issue registers and held stable until the next ISSUE.
    - Pop the FIFO; go to WAIT.
  - WAIT:
    - div_valid=0.
    - div_ready=1: capture div_quotient, div_remainder, resp_err=0 and tag; go to RESP.
    - div_error=1: capture resp_quotient=0, resp_remainder=0, resp_err=1; go to RESP.
    - If div_ready and div_error assert together, div_error wins.
  - RESP:
    - resp_valid=1; outputs stay stable until resp_valid & resp_ready.
    - On that handshake go to IDLE. The earliest next ISSUE is the following cycle.
- div_valid must never assert outside ISSUE, because a divider start pulse restarts its iteration counter.
  - Minimum spacing between start pulses is 3 cycles, which guarantees the divider has returned to its idle state.
- Latency from req accept with an empty FIFO to resp_valid: 2 + divider latency. The divider latency is 2 cycles for divisor==0 or 1, and WID/2+3 otherwise.
- Pulses outside WAIT: a div_ready or div_error pulse outside WAIT is ignored.
- Reset mid-operation: the FIFO is flushed and the in-flight request is dropped. The divider shares rst, so it is also reset.

Optional Feature:
- Macro: SRT_DIV_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter (log2(TIMEOUT+1) bits) clears on ISSUE.
  - If it reaches TIMEOUT with no div_ready/div_error, respond resp_err=1, quotient=0, remainder=0, and go to RESP.
  - A later stray div_ready is ignored.
- Undefined: no counter; WAIT is unbounded.

Decomposition:
- Shared package (srt_div_pkg):
  - FSM state encoding: IDLE, ISSUE, WAIT, RESP.
  - Request struct: {tag, sign, divisor, dividend}.
  - Response struct: {tag, err, remainder, quotient}.
  - Default WID/TAGW constants.
- One sub-module, srt_req_fifo: parameterised synchronous FIFO with push/pop, full/empty, count.

Test Plan:
- Unsigned basic: WID=8, 100/7, tag 3 → resp_quotient=14, resp_remainder=2, resp_err=0, resp_tag=3; div_valid asserted exactly 1 cycle.
- Signed: sign=1, 0xF9 (−7) / 0x02 → quotient=0xFD (−3), remainder=0xFF (−1).
- Divide-by-zero then divide-by-one back-to-back:
  - 55/0 → resp_err=1, quotient=0.
  - 55/1 → quotient=55, remainder=0.
  - Tags are returned in request order.
- FIFO full / backpressure:
  - Hold resp_ready=0 and push 5 requests with DEPTH=4: the 1st is issued, 4 are queued, and req_ready drops after the 5th push.
  - Release resp_ready: all 5 responses arrive in order, and no div_valid occurs while in RESP.
- Reset mid-operation: assert rst during WAIT with 2 requests queued → next cycle: all outputs 0, req_ready=1, no response emitted.
- Timeout (SRT_DIV_TIMEOUT_EN, TIMEOUT=16): divider model never responds → resp_err=1 after 16 WAIT cycles; a late div_ready pulse is ignored.
